// File: rtl/key_press_classifier.sv
// Purpose: classify debounced key gestures as single click, double click or long press.
// Latency: pulses are registered, one cycle after the timeout or release edge that decides the gesture.
// Backpressure: none; the event pulses are fire-and-forget and the downstream logic has no ready.
// Optional feature: define KEY_REPEAT_EN to repeat long_press every CNT_RPT cycles while held.
module key_press_classifier #(
    parameter logic [25:0] CNT_LONG = 26'd49_999_999,
    parameter logic [25:0] CNT_GAP  = 26'd14_999_999,
    parameter logic [19:0] CNT_REL  = 20'd999_999
`ifdef KEY_REPEAT_EN
    ,
    parameter logic [25:0] CNT_RPT  = 26'd9_999_999
`endif
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    input  logic key_in,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    localparam logic [25:0] CNT_LONG_M1 = CNT_LONG - 26'd1;
    localparam logic [25:0] CNT_GAP_M1  = CNT_GAP - 26'd1;
    localparam logic [19:0] CNT_REL_M1  = CNT_REL - 20'd1;
`ifdef KEY_REPEAT_EN
    localparam logic [25:0] CNT_RPT_M1  = CNT_RPT - 26'd1;
`endif

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [19:0] rel_cnt_q, rel_cnt_d;
    logic        rel_ok;
    logic        rpt_tick;
    logic        single_d, double_d, long_d, busy_d;
    logic        single_q, double_q, long_q, busy_q;

    // Release filter: count consecutive high cycles, saturating so rel_ok fires once per release.
    always_comb begin
        rel_cnt_d = rel_cnt_q;
        if (!key_in) begin
            rel_cnt_d = '0;
        end else if (rel_cnt_q != CNT_REL) begin
            rel_cnt_d = rel_cnt_q + 20'd1;
        end
    end

    assign rel_ok = key_in && (rel_cnt_q == CNT_REL_M1);

    // State, timer, release counter and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rel_cnt_q <= '0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rel_cnt_q <= rel_cnt_d;
            single_q  <= single_d;
            double_q  <= double_d;
            long_q    <= long_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state: release beats long timeout, second press beats gap timeout.
    always_comb begin
        state_d  = state_q;
        rpt_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_flag) state_d = PRESS1;
            end
            PRESS1: begin
                if (rel_ok)                    state_d = GAP;
                else if (cnt_q == CNT_LONG_M1) state_d = LONG;
            end
            GAP: begin
                if (key_flag)                 state_d = PRESS2;
                else if (cnt_q == CNT_GAP_M1) state_d = IDLE;
            end
            PRESS2: begin
                if (rel_ok) state_d = IDLE;
            end
            LONG: begin
                if (rel_ok) begin
                    state_d = IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt_q == CNT_RPT_M1) begin
                    rpt_tick = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Gesture timer: restarts on every state change (and on each repeat tick), idle in IDLE/PRESS2.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && !rpt_tick) begin
            if ((state_q == PRESS1) || (state_q == GAP) || (state_q == LONG)) begin
                cnt_d = cnt_q + 26'd1;
            end
        end
    end

    // Output decode: a pulse is raised on the edge of the transition that decides the gesture.
    always_comb begin
        single_d = (state_q == GAP) && (state_d == IDLE);
        double_d = (state_q == PRESS2) && (state_d == IDLE);
        long_d   = ((state_q == PRESS1) && (state_d == LONG)) || rpt_tick;
        busy_d   = (state_d != IDLE);
    end

    assign single_click = single_q;
    assign double_click = double_q;
    assign long_press   = long_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Purpose: directed and randomized gesture stimulus checked against a timeline-based reference model.
// Latency: every cycle's outputs are recorded and compared against the model after the stimulus ends.
// Backpressure: not applicable.
module tb_key_press_classifier;

    localparam int P_LONG = 100;
    localparam int P_GAP  = 40;
    localparam int P_REL  = 10;
    localparam int P_RPT  = 30;
    localparam int MAXC   = 12000;

    logic sys_clk;
    logic sys_rst_n;
    logic key_flag;
    logic key_in;
    logic single_click, double_click, long_press, busy;

    key_press_classifier #(
        .CNT_LONG(26'd100),
        .CNT_GAP (26'd40),
        .CNT_REL (20'd10)
`ifdef KEY_REPEAT_EN
        ,
        .CNT_RPT (26'd30)
`endif
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_flag    (key_flag),
        .key_in      (key_in),
        .single_click(single_click),
        .double_click(double_click),
        .long_press  (long_press),
        .busy        (busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Recorded timeline: index t is the t-th rising edge after time zero.
    logic       flag_a [MAXC];
    logic       kin_a  [MAXC];
    logic       rst_a  [MAXC];
    logic [3:0] obs_a  [MAXC];   // {busy, long, double, single} sampled after edge t
    logic [3:0] exp_a  [MAXC];
    bit         relok_a[MAXC];
    int         cyc_n;
    int         n_chk;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic cyc(input logic f, input logic k);
        if (cyc_n >= MAXC) begin
            $display("FAIL cycle_budget: observed %0d expected below %0d", cyc_n, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        key_flag      = f;
        key_in        = k;
        flag_a[cyc_n] = f;
        kin_a[cyc_n]  = k;
        rst_a[cyc_n]  = !sys_rst_n;
        @(posedge sys_clk);
        @(negedge sys_clk);
        obs_a[cyc_n] = {busy, long_press, double_click, single_click};
        cyc_n++;
    endtask

    task automatic do_reset(input int n);
        sys_rst_n = 1'b0;
        repeat (n) cyc(1'b0, 1'b1);
        sys_rst_n = 1'b1;
    endtask

    // Press: flag on the first low cycle, hold low, optional release bounces, then stay high.
    task automatic press(input int hold, input int nb, input int bh, input int bl,
                         input int high, input bit noisy);
        cyc(1'b1, 1'b0);
        for (int i = 1; i < hold; i++) cyc(noisy && ($urandom_range(0, 19) == 0), 1'b0);
        for (int b = 0; b < nb; b++) begin
            repeat (bh) cyc(1'b0, 1'b1);
            repeat (bl) cyc(1'b0, 1'b0);
        end
        repeat (high) cyc(1'b0, 1'b1);
    endtask

    function automatic int next_rst(input int t);
        for (int u = t; u < cyc_n; u++) if (rst_a[u]) return u;
        return cyc_n;
    endfunction

    function automatic int first_relok(input int a, input int lim);
        for (int u = a + 1; u < lim; u++) if (relok_a[u]) return u;
        return lim;
    endfunction

    function automatic int first_flag(input int a, input int lim);
        for (int u = a + 1; u < lim; u++) if (flag_a[u]) return u;
        return lim;
    endfunction

    function automatic int cnt_bit(input int b, input int a, input int e);
        int c = 0;
        for (int u = a; u < e; u++) c += int'(obs_a[u][b]);
        return c;
    endfunction

    // Reference: find release confirmations from run lengths, then walk gestures event by event.
    task automatic compute_model();
        int run = 0;
        int t, f, lim, r, tl, g, f2, tg, r2, e;
        for (int u = 0; u < cyc_n; u++) begin
            exp_a[u] = 4'b0000;
            if (rst_a[u])     run = 0;
            else if (kin_a[u]) run = run + 1;
            else              run = 0;
            relok_a[u] = (run == P_REL);
        end
        t = 0;
        while (t < cyc_n) begin
            if (rst_a[t] || !flag_a[t]) begin
                t++;
                continue;
            end
            f   = t;
            lim = next_rst(f);
            r   = first_relok(f, lim);
            tl  = f + P_LONG;
            if ((r < lim) && (r <= tl)) begin
                g  = r;
                f2 = first_flag(g, lim);
                tg = g + P_GAP;
                if ((f2 < lim) && (f2 <= tg)) begin
                    r2 = first_relok(f2, lim);
                    if (r2 < lim) exp_a[r2][1] = 1'b1;
                    e = r2;
                end else if (tg < lim) begin
                    exp_a[tg][0] = 1'b1;
                    e = tg;
                end else begin
                    e = lim;
                end
            end else if (tl < lim) begin
                exp_a[tl][2] = 1'b1;
`ifdef KEY_REPEAT_EN
                for (int k = tl + P_RPT; k < r; k += P_RPT) exp_a[k][2] = 1'b1;
`endif
                e = r;
            end else begin
                e = lim;
            end
            for (int u = f; u < e; u++) exp_a[u][3] = 1'b1;
            t = e + 1;
        end
    endtask

    int f, f2, exp_long;
    int hold, nb, bh, bl, gap, hold2;

    initial begin
        cyc_n     = 0;
        n_chk     = 0;
        n_fail    = 0;
        sys_rst_n = 1'b0;
        key_flag  = 1'b0;
        key_in    = 1'b1;

        // Reset state
        do_reset(3);
        chk("reset_outputs", obs_a[2], 4'b0000);
        repeat (20) cyc(1'b0, 1'b1);

        // Single click: release confirmed at f+39, timeout 40 later
        f = cyc_n;
        press(30, 0, 0, 0, 100, 1'b0);
        chk("single_busy_rise", obs_a[f][3], 1);
        chk("single_time", obs_a[f+79][0], 1);
        chk("single_busy_before", obs_a[f+78][3], 1);
        chk("single_busy_fall", obs_a[f+79][3], 0);
        chk("single_count", cnt_bit(0, f, cyc_n), 1);
        chk("single_no_other", cnt_bit(1, f, cyc_n) + cnt_bit(2, f, cyc_n), 0);

        // Double click: second press 20 cycles into the gap
        f = cyc_n;
        press(30, 0, 0, 0, 29, 1'b0);
        press(30, 0, 0, 0, 100, 1'b0);
        chk("double_time", obs_a[f+98][1], 1);
        chk("double_count", cnt_bit(1, f, cyc_n), 1);
        chk("double_no_single", cnt_bit(0, f, cyc_n), 0);

        // Long press held 250 cycles
        f = cyc_n;
        press(250, 0, 0, 0, 100, 1'b0);
`ifdef KEY_REPEAT_EN
        exp_long = 6;
`else
        exp_long = 1;
`endif
        chk("long_time", obs_a[f+100][2], 1);
        chk("long_count", cnt_bit(2, f, cyc_n), exp_long);
        chk("long_no_click", cnt_bit(0, f, cyc_n) + cnt_bit(1, f, cyc_n), 0);

        // Second key_flag on the gap-timeout cycle
        f = cyc_n;
        press(30, 0, 0, 0, 49, 1'b0);
        press(20, 0, 0, 0, 100, 1'b0);
        chk("gapedge_no_single", cnt_bit(0, f, cyc_n), 0);
        chk("gapedge_double", obs_a[f+108][1], 1);

        // Release confirmed on the long-timeout cycle
        f = cyc_n;
        press(91, 0, 0, 0, 60, 1'b0);
        chk("longedge_no_long", cnt_bit(2, f, cyc_n), 0);
        chk("longedge_single", obs_a[f+140][0], 1);

        // Release bounce: 3x (high 5, low 2), final rise at f+51
        f = cyc_n;
        press(30, 3, 5, 2, 100, 1'b0);
        chk("bounce_single_time", obs_a[f+100][0], 1);
        chk("bounce_single_count", cnt_bit(0, f, cyc_n), 1);
        chk("bounce_no_long", cnt_bit(2, f, cyc_n), 0);

        // Reset during GAP
        f = cyc_n;
        press(30, 0, 0, 0, 20, 1'b0);
        do_reset(3);
        repeat (60) cyc(1'b0, 1'b1);
        chk("rst_outputs_mid", obs_a[f+51], 4'b0000);
        chk("rst_outputs_end", obs_a[f+52], 4'b0000);
        chk("rst_busy_after", obs_a[f+53][3], 0);
        chk("rst_no_pulse", cnt_bit(0, f, cyc_n) + cnt_bit(1, f, cyc_n) + cnt_bit(2, f, cyc_n), 0);
        f2 = cyc_n;
        press(30, 0, 0, 0, 100, 1'b0);
        chk("rst_fresh_busy", obs_a[f2][3], 1);
        chk("rst_fresh_single", obs_a[f2+79][0], 1);

        // Randomized gestures with bounces, stray flags and occasional resets
        for (int n = 0; n < 15; n++) begin
            hold = $urandom_range(5, 150);
            nb   = $urandom_range(0, 2);
            bh   = $urandom_range(1, 8);
            bl   = $urandom_range(1, 3);
            gap  = $urandom_range(5, 60);
            if ($urandom_range(0, 1) == 1) begin
                press(hold, nb, bh, bl, gap, 1'b1);
                if ($urandom_range(0, 4) == 0) do_reset(2);
                hold2 = $urandom_range(5, 150);
                press(hold2, $urandom_range(0, 2), bh, bl, 80, 1'b1);
            end else begin
                press(hold, nb, bh, bl, 80, 1'b1);
            end
        end
        repeat (200) cyc(1'b0, 1'b1);

        // Whole-timeline comparison against the reference model
        compute_model();
        for (int u = 0; u < cyc_n; u++) begin
            chk($sformatf("model_cycle_%0d", u), obs_a[u], exp_a[u]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_press_classifier.md
Name: key_press_classifier

Overview:
- Sits directly downstream of the key debounce stage.
- Consumes the one-cycle debounced press pulse plus the raw active-low key level.
- Classifies each gesture as single click, double click or long press, and emits one-cycle event pulses to the application logic (LED/mode control).
- Needs one FSM, one shared gesture timer and one release-debounce counter.

Parameters:
- CNT_LONG, 26'd49_999_999: cycles a first press must be held to count as long press (1 s @ 50 MHz).
- CNT_GAP, 26'd14_999_999: max release-to-second-press gap for a double click (300 ms).
- CNT_REL, 20'd999_999: cycles key_in must stay high to confirm release (20 ms).
- CNT_RPT, 26'd9_999_999: auto-repeat period, used only with KEY_REPEAT_EN (200 ms).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous, active-low reset.
- key_flag  input  1  one-cycle pulse: debounced press confirmed.
- key_in  input  1  raw key level; 0 = pressed, 1 = released.
- single_click  output  1  one-cycle pulse: single click classified.
- double_click  output  1  one-cycle pulse: double click classified.
- long_press  output  1  one-cycle pulse: long press (and repeats when enabled).
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async, sys_rst_n=0):
  - state=IDLE.
  - Gesture timer cnt=0; release counter rel_cnt=0.
  - All four outputs 0.
- All outputs are registered. Each pulse is exactly 1 cycle, asserted on the same edge as the state transition that causes it.
- Release counter:
  - Clears to 0 while key_in=0.
  - Increments while key_in=1, saturating at CNT_REL.
  - rel_ok = (rel_cnt==CNT_REL-1 && key_in==1): a single-cycle event.
- Gesture timer: cleared to 0 on every state change; otherwise increments each cycle in PRESS1/GAP/LONG; held at 0 in IDLE/PRESS2.
- States and transitions:
  - IDLE: key_flag -> PRESS1.
  - PRESS1: rel_ok -> GAP. Else cnt==CNT_LONG-1 -> LONG, pulse long_press.
  - GAP: key_flag -> PRESS2. Else cnt==CNT_GAP-1 -> IDLE, pulse single_click.
  - PRESS2: rel_ok -> IDLE, pulse double_click. Hold duration in PRESS2 is ignored (no long press).
  - LONG: rel_ok -> IDLE, no pulse.
- Latency:
  - long_press rises CNT_LONG cycles after PRESS1 entry.
  - single_click rises CNT_GAP cycles after GAP entry.
  - double_click rises on the edge after rel_ok in PRESS2.
- Simultaneous events:
  - PRESS1, rel_ok and long timeout in the same cycle: release wins, go to GAP, no long_press.
  - GAP, key_flag and gap timeout in the same cycle: key_flag wins, go to PRESS2, no single_click.
  - key_flag in PRESS1/PRESS2/LONG is ignored.
- Reset mid-gesture: returns to IDLE immediately and pending classification is discarded; no pulse is emitted on reset release.
- Counter widths must hold CNT_* - 1 without wrap; comparisons use full width.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In LONG, cnt counts to CNT_RPT-1; on reaching it, pulse long_press and clear cnt.
  - This repeats until rel_ok.
  - If rel_ok coincides with a repeat tick, rel_ok wins and no pulse is emitted.
- Undefined: LONG only waits for rel_ok; exactly one long_press per gesture; the CNT_RPT logic is absent.

Test Plan:
All scenarios use sim params CNT_LONG=100, CNT_GAP=40, CNT_REL=10, CNT_RPT=30.
- Single click: key_flag pulse, key_in low 30 cycles then high -> single_click exactly 1 pulse, 40 cycles after GAP entry. No other pulses. busy falls the same edge.
- Double click: press 30, release, second key_flag 20 cycles after GAP entry, release -> double_click 1 pulse on the edge after rel_ok. single_click never asserted.
- Long press: key_flag, hold 250 cycles -> long_press at cycle 100. With KEY_REPEAT_EN, further pulses at +30, +60, ... until release. Without the macro, exactly one pulse. No click pulses on release.
- Boundaries:
  - Second key_flag on the same cycle as gap timeout -> PRESS2, no single_click.
  - Release confirmed on the cycle of long timeout -> GAP, no long_press.
- Release bounce: after the press, key_in toggles high 5 cycles / low 2 cycles three times, then stays high -> exactly one transition to GAP, 10 cycles after the final rise.
- Reset mid-gesture: sys_rst_n low during GAP for 3 cycles -> all outputs 0, busy 0. No pulse after deassertion; the next key_flag starts a fresh PRESS1.
